// File: rtl/latch_load_ctrl.sv
// latch_load_ctrl: assembles a serial MSB-first bit stream into a WIDTH-bit word and
// drives a level-sensitive latch bank with a setup / enable / hold sequence.
// Optional feature macro: PARITY_CHECK_EN (adds a trailing even-parity bit per word).
module latch_load_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EN_CYCLES = 2,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin_i,
  input  logic             svalid_i,
  output logic             sready_o,
  output logic [WIDTH-1:0] d_out_o,
  output logic             en_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             perr_o
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
  localparam int unsigned FRAME_BITS = WIDTH;
`endif

  // One counter serves both bit counting and phase timing, so size it for the largest use.
  localparam int unsigned MAX_A   = (FRAME_BITS > SETUP_CYC) ? FRAME_BITS : SETUP_CYC;
  localparam int unsigned MAX_B   = (MAX_A > EN_CYCLES) ? MAX_A : EN_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_B > HOLD_CYC) ? MAX_B : HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_SETUP,
    S_ENABLE,
    S_HOLD
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               perr_q, perr_d;
  logic               sready_q, sready_d;
  logic [WIDTH-1:0]   shift_c;
  logic [CNT_W-1:0]   acc_cnt_c;

  // State and registered outputs; EN comes straight from a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sreg_q   <= '0;
      dout_q   <= '0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      perr_q   <= 1'b0;
      sready_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sreg_q   <= sreg_d;
      dout_q   <= dout_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      perr_q   <= perr_d;
      sready_q <= sready_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they register with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    dout_d    = dout_q;
    perr_d    = 1'b0;
    shift_c   = (sreg_q << 1) | WIDTH'(sin_i);
    acc_cnt_c = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE, S_SHIFT: begin
        if (svalid_i) begin
          if (acc_cnt_c <= CNT_W'(WIDTH)) sreg_d = shift_c;
`ifdef PARITY_CHECK_EN
          if (acc_cnt_c == CNT_W'(WIDTH + 1)) begin
            cnt_d = '0;
            if ((^{sreg_q, sin_i}) == 1'b0) begin
              dout_d  = sreg_q;
              state_d = S_SETUP;
            end else begin
              perr_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            cnt_d   = acc_cnt_c;
            state_d = S_SHIFT;
          end
`else
          if (acc_cnt_c == CNT_W'(WIDTH)) begin
            dout_d  = shift_c;
            cnt_d   = '0;
            state_d = S_SETUP;
          end else begin
            cnt_d   = acc_cnt_c;
            state_d = S_SHIFT;
          end
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_ENABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ENABLE: begin
        if (cnt_q == CNT_W'(EN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    en_d     = (state_d == S_ENABLE);
    busy_d   = (state_d == S_SETUP) || (state_d == S_ENABLE) || (state_d == S_HOLD);
    sready_d = (state_d == S_IDLE) || (state_d == S_SHIFT);
    done_d   = (state_q == S_HOLD) && (state_d == S_IDLE);
  end

  assign sready_o = sready_q;
  assign d_out_o  = dout_q;
  assign en_out_o = en_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign perr_o   = perr_q;

endmodule
